// File: rtl/serial_cfg_lut_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_cfg_lut_pkg
//  Description : Shared types and sizing helpers for the serially configured
//                lookup table (FSM states, chain length, counter width).
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_cfg_lut_pkg;

   // Load/commit controller states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   // Configuration chain length: one bit per output per table entry
   function automatic int chain_len(input int n_in, input int n_out);
      return n_out * (1 << n_in);
   endfunction

   // Bit counter must hold 0..L+1 (L+1 marks an over-length load)
   function automatic int cnt_width(input int l);
      return $clog2(l + 2);
   endfunction

   // Default geometry (3-input, 7-output table)
   localparam int c_DEF_L     = chain_len(3, 7);
   localparam int c_DEF_CNT_W = cnt_width(c_DEF_L);

endpackage
`default_nettype wire

// File: rtl/serial_cfg_lut_io_sync.sv
`default_nettype none
// ============================================================================
//  Module      : serial_cfg_lut_io_sync
//  Description : Multi-flop synchroniser for an asynchronous input with a
//                configurable reset level and registered rise/fall pulses.
//                The pulses are high for exactly the first clk cycle in which
//                o_sync shows the new level. STAGES must be at least 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_cfg_lut_io_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic i_async,
   output logic o_sync,
   output logic o_rise,
   output logic o_fall
);

   logic [STAGES-1:0] r_ff;
   logic              r_rise;
   logic              r_fall;

   // Shift the pin through the synchroniser; the pulses look one stage ahead
   // so that they line up with the first cycle of the new synced level,
   // equivalent to comparing the synced value against a one-flop delayed copy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ff   <= {STAGES{RST_VAL}};
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_ff   <= {r_ff[STAGES-2:0], i_async};
         r_rise <=  r_ff[STAGES-2] & ~r_ff[STAGES-1];
         r_fall <= ~r_ff[STAGES-2] &  r_ff[STAGES-1];
      end
   end

   assign o_sync = r_ff[STAGES-1];
   assign o_rise = r_rise;
   assign o_fall = r_fall;

endmodule
`default_nettype wire

// File: rtl/serial_cfg_lut.sv
`default_nettype none
// ============================================================================
//  Module      : serial_cfg_lut
//  Description : Serially configured N_IN-input / N_OUT-output lookup table.
//                A shadow chain is loaded LSB first while ce is low and is
//                copied to the active table on the ce rising edge only if
//                exactly L bits were shifted in.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_cfg_lut
   import serial_cfg_lut_pkg::*;
#(
   parameter int N_IN        = 3,
   parameter int N_OUT       = 7,
   parameter int SYNC_STAGES = 2,
   parameter int REG_OUT     = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_sclk,
   input  logic             i_ce,
   input  logic             i_sin,
   input  logic [N_IN-1:0]  i_in,
   output logic [N_OUT-1:0] o_out,
   output logic             o_sout,
   output logic             o_cfg_valid,
   output logic             o_cfg_err
);

   localparam int c_DEPTH = 1 << N_IN;
   localparam int c_L     = chain_len(N_IN, N_OUT);
   localparam int c_CNT_W = cnt_width(c_L);
   localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(c_L);
   localparam logic [c_CNT_W-1:0] c_CNT_SAT  = c_CNT_W'(c_L + 1);

   // Synchronised pins and edge pulses
   logic w_sclk_s, w_sclk_rise, w_sclk_fall;
   logic w_ce_s, w_ce_rise, w_ce_fall;
   logic w_sin_s, w_sin_rise, w_sin_fall;

   // Controller
   state_t r_state;
   state_t w_state_nxt;
   logic   w_shift_en;
   logic   w_cnt_clr;
   logic   w_commit;

   // Datapath
   logic [c_L-1:0]     r_chain;
   logic [c_L-1:0]     r_active;
   logic [c_CNT_W-1:0] r_cnt;
   logic               r_cfg_valid;
   logic               r_cfg_err;
   logic [N_OUT-1:0]   w_lut;

   serial_cfg_lut_io_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
      .clk     (clk),
      .reset   (reset),
      .i_async (i_sclk),
      .o_sync  (w_sclk_s),
      .o_rise  (w_sclk_rise),
      .o_fall  (w_sclk_fall)
   );

   serial_cfg_lut_io_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ce (
      .clk     (clk),
      .reset   (reset),
      .i_async (i_ce),
      .o_sync  (w_ce_s),
      .o_rise  (w_ce_rise),
      .o_fall  (w_ce_fall)
   );

   serial_cfg_lut_io_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sin (
      .clk     (clk),
      .reset   (reset),
      .i_async (i_sin),
      .o_sync  (w_sin_s),
      .o_rise  (w_sin_rise),
      .o_fall  (w_sin_fall)
   );

   // Controller state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and datapath strobes; a ce rise in SHIFT takes priority over
   // a coincident sclk rise so the final edge cannot sneak in an extra bit.
   always_comb begin
      w_state_nxt = r_state;
      w_shift_en  = 1'b0;
      w_cnt_clr   = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_ce_fall) begin
               w_state_nxt = ST_SHIFT;
               w_cnt_clr   = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (w_ce_rise) begin
               w_state_nxt = ST_COMMIT;
            end else if (w_sclk_rise && !w_ce_s) begin
               w_shift_en = 1'b1;
            end
         end
         ST_COMMIT: begin
            w_commit    = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Shadow chain and saturating bit counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_chain <= '0;
         r_cnt   <= '0;
      end else if (w_cnt_clr) begin
         r_cnt <= '0;
      end else if (w_shift_en) begin
         r_chain <= {w_sin_s, r_chain[c_L-1:1]};
         if (r_cnt != c_CNT_SAT) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // Commit: only an exact-length load replaces the active table
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_active    <= '0;
         r_cfg_valid <= 1'b0;
         r_cfg_err   <= 1'b0;
      end else if (w_commit) begin
         if (r_cnt == c_CNT_FULL) begin
            r_active    <= r_chain;
            r_cfg_valid <= 1'b1;
            r_cfg_err   <= 1'b0;
         end else begin
            r_cfg_err   <= 1'b1;
         end
      end
   end

   // Output bit j is row j of the table, indexed by the input code
   for (genvar j = 0; j < N_OUT; j++) begin : g_row
      logic [c_DEPTH-1:0] w_row;
      assign w_row    = r_active[j*c_DEPTH +: c_DEPTH];
      assign w_lut[j] = w_row[i_in];
   end

   if (REG_OUT != 0) begin : g_reg_out
      logic [N_OUT-1:0] r_out;
      // Register the table lookup for a clean, glitch-free output
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_out <= '0;
         end else begin
            r_out <= w_lut;
         end
      end
      assign o_out = r_out;
   end else begin : g_comb_out
      assign o_out = w_lut;
   end

   assign o_sout      = r_chain[0];
   assign o_cfg_valid = r_cfg_valid;
   assign o_cfg_err   = r_cfg_err;

endmodule
`default_nettype wire
